// File: rtl/bus_shift_arbiter.sv
// bus_shift_arbiter: round-robin arbiter and tag tracker that shares one
// fixed-latency bus_shift delay line between N_REQ requesters. The granted
// word goes onto dl_in, and a DELAY-deep valid/ID pipeline follows it so that
// the word leaving dl_out is returned as a response tagged with its owner.
// Optional macro BUS_SHIFT_ARB_FLUSH_EN adds a flush input that drops all
// in-flight words without disturbing the round-robin pointer.
module bus_shift_arbiter #(
  parameter int WIDTH = 10,
  parameter int DELAY = 4,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = $clog2(DELAY + 1)
) (
  input  logic                   clk,
  input  logic                   srst,
`ifdef BUS_SHIFT_ARB_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       dl_in,
  input  logic [WIDTH-1:0]       dl_out,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [CNT_W-1:0]       inflight
);

  logic              flush_act;
  logic              blocked;
  logic              grant;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   ptr;
  logic [DELAY-1:0]  vld_pipe;
  logic [ID_W-1:0]   id_pipe [DELAY];

`ifdef BUS_SHIFT_ARB_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // No grant may be issued while the tracking state is being cleared.
  assign blocked = srst | flush_act;

  // ---- stage: arbitration (combinational, ahead of the delay line) ----
  // Round-robin search starting at ptr, ascending with wrap; first set bit wins.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant && req_valid[(int'(ptr) + k) % N_REQ]) begin
        grant  = 1'b1;
        winner = ID_W'((int'(ptr) + k) % N_REQ);
      end
    end
    if (blocked) begin
      grant = 1'b0;
    end
  end

  assign req_ready = grant ? (N_REQ'(1) << winner) : '0;
  assign dl_in     = grant ? req_data[winner*WIDTH +: WIDTH] : '0;

  // ---- stage: tag pipeline (runs in lock-step with the external delay line) ----
  // Pointer, valid/ID shift registers and in-flight count; vld_pipe is the
  // sole authority on whether dl_out carries a live word.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr      <= '0;
      vld_pipe <= '0;
      inflight <= '0;
      for (int i = 0; i < DELAY; i++) begin
        id_pipe[i] <= '0;
      end
    end else begin
      if (grant) begin
        if (int'(winner) == N_REQ - 1) begin
          ptr <= '0;
        end else begin
          ptr <= winner + 1'b1;
        end
      end

      if (flush_act) begin
        vld_pipe <= '0;
        inflight <= '0;
      end else begin
        vld_pipe[0] <= grant;
        for (int i = 1; i < DELAY; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
        end
        // A retire is the word currently shown on rsp_valid.
        case ({grant, vld_pipe[DELAY-1]})
          2'b10:   inflight <= inflight + CNT_W'(1);
          2'b01:   inflight <= inflight - CNT_W'(1);
          default: inflight <= inflight;
        endcase
      end

      id_pipe[0] <= winner;
      for (int i = 1; i < DELAY; i++) begin
        id_pipe[i] <= id_pipe[i-1];
      end
    end
  end

  // ---- stage: response (aligned with dl_out) ----
  assign rsp_valid = vld_pipe[DELAY-1];
  assign rsp_id    = id_pipe[DELAY-1];
  assign rsp_data  = dl_out;

endmodule

// File: doc/bus_shift_arbiter.md
Name: bus_shift_arbiter

Overview:
Round-robin arbiter and tag tracker that shares a single fixed-latency bus_shift delay line (DELAY cycles, WIDTH bits) between N_REQ requesters. Each cycle it grants at most one requester and drives the winner's word onto the delay-line input. A DELAY-deep valid/ID pipeline tracks ownership, so the word emerging at the delay-line output is returned as a response tagged with its requester ID. The block sits in fv/aux_logic beside bus_shift and is used to build shared, fixed-latency checking pipelines.

Parameters:
WIDTH, 10, data width of each request word and of the delay line.
DELAY, 4, latency of the attached delay line in clock cycles; must be >= 1.
N_REQ, 4, number of requesters; must be >= 2.
ID_W, $clog2(N_REQ), width of the requester ID.

Ports:
clk  input  1  clock. Rising-edge only.
srst  input  1  reset: one clock; reset is synchronous and active-high.
req_valid  input  N_REQ  request valid, one bit per requester.
req_data  input  N_REQ*WIDTH  request words; requester i uses bits [i*WIDTH +: WIDTH].
req_ready  output  N_REQ  one-hot grant (combinational); a transfer occurs on req_valid[i] & req_ready[i].
dl_in  output  WIDTH  to the delay-line input (combinational); the granted word, or 0 when there is no grant.
dl_out  input  WIDTH  from the delay-line output.
rsp_valid  output  1  response valid; registered, taken from the tag pipeline.
rsp_id  output  ID_W  requester ID of the response.
rsp_data  output  WIDTH  equals dl_out (pass-through).
inflight  output  $clog2(DELAY+1)  number of words currently in the delay line.

Behaviour:
- Reset (srst=1 at an edge):
  - vld_pipe clears to all 0; id_pipe clears to 0.
  - ptr = 0, inflight = 0, rsp_valid = 0, rsp_id = 0.
  - req_ready = 0 while srst is high.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, ascending, wrapping at N_REQ-1 to 0.
  - The first set bit wins: req_ready = one-hot(winner), dl_in = req_data[winner].
  - No valid bit: req_ready = 0, dl_in = 0.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update:
  - On a grant, ptr <= (winner+1) mod N_REQ.
  - With no grant, ptr holds its value.
  - Result: a continuously requesting source waits at most N_REQ-1 cycles.
- Tag pipeline:
  - Shift registers vld_pipe[0..DELAY-1] and id_pipe[0..DELAY-1] advance every cycle.
  - Stage 0 loads (grant, winner).
  - rsp_valid = vld_pipe[DELAY-1], rsp_id = id_pipe[DELAY-1].
  - A word granted at edge t appears with rsp_valid = 1 in the cycle after edge t+DELAY-1, aligned with dl_out (exactly DELAY cycles of latency).
- No backpressure on responses: rsp_valid is a one-cycle pulse per word. The issue rate is at most one word per cycle.
- inflight:
  - +1 on a grant without a retire, -1 on a retire (rsp_valid) without a grant.
  - Unchanged when both or neither occur.
  - Range 0..DELAY; it never exceeds DELAY.
- Reset mid-operation:
  - All in-flight words are dropped; dl_out contents are ignored because vld_pipe is cleared.
  - rsp_valid stays 0 for at least DELAY cycles after reset is released, unless new grants are made.
  - The delay line's own reset is independent; this block's validity tracking alone governs responses.
- DELAY = 1: the pipeline is a single stage; a response appears one cycle after its grant.

Optional Feature:
BUS_SHIFT_ARB_FLUSH_EN
- Defined:
  - Adds input port flush (1 bit).
  - flush = 1 at an edge clears vld_pipe and inflight, as reset does.
  - ptr is retained.
  - req_ready is forced to 0 during any cycle with flush = 1.
  - rsp_valid goes to 0 in the next cycle and stays 0 until new grants propagate.
- Undefined: no flush port; behaviour is as above.

Test Plan:
- Reset release, all req_valid = 0 for 10 cycles -> req_ready = 0, rsp_valid = 0, inflight = 0, dl_in = 0 throughout.
- Single request: requester 2 valid for one cycle, data 0x155, DELAY = 4 -> req_ready = 4'b0100 that cycle; 4 cycles later rsp_valid = 1 for one cycle with rsp_id = 2 and rsp_data = 0x155; inflight goes 1 then back to 0.
- All four requesters continuously valid -> grant order 0,1,2,3,0,1,...; steady-state inflight = 4; rsp_id sequence repeats 0,1,2,3 starting DELAY cycles after the first grant.
- Requesters 1 and 3 valid, ptr = 2 -> requester 3 is granted first, then 1, then 3; ptr follows 0 then 2 then 0.
- srst asserted for 1 cycle while inflight = 3 -> rsp_valid = 0 for the next 4 cycles, inflight = 0, ptr = 0.
- With BUS_SHIFT_ARB_FLUSH_EN: flush pulsed at inflight = 4, ptr = 1 -> no responses for the flushed words, inflight = 0, ptr stays 1, req_ready = 0 during the flush cycle.
